pwm_ctrl: RTL and testbench
===========================

PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, peripheral clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: cfg_valid in 1, write request; cfg_ready out 1, write accept; cfg_addr in 3, register select; cfg_wdata in 16, write data.
REQ-003 SHALL have ports: pwm_en out 1; functions out 8; period out 16; compare1 out 16; compare2 out 16; count_val out 16. These are the active settings driven to the PWM generator.
REQ-004 SHALL have ports: period_irq out 1, one-cycle pulse on counter wrap; upd_pending out 1, commit armed.
REQ-005 SHALL use one clock domain (clk); reset is asynchronous, active-low (rst_n).

Function
REQ-006 SHALL accept a write on a cycle with cfg_valid=1 and cfg_ready=1; a write takes effect at the next clk edge.
REQ-007 SHALL decode cfg_addr as follows: 0 CTRL (bit0 EN, bits2:1 FUNC, bit3 UPD, bit4 ONESHOT); 1 PERIOD; 2 CMP1; 3 CMP2; 4 PRESCALE (bits7:0). Addresses 5-7 SHALL be accepted and ignored.
REQ-008 SHALL write FUNC, PERIOD, CMP1, CMP2 and PRESCALE into shadow registers only, never directly to the outputs.
REQ-009 SHALL update the EN bit of CTRL directly; pwm_en SHALL follow it on the cycle after the write.
REQ-010 SHALL arm a commit when CTRL is written with UPD=1 (self-clearing); upd_pending SHALL be 1 from the next cycle until the commit completes.
REQ-011 SHALL drive cfg_ready=0 while upd_pending=1 and 1 otherwise; no write SHALL be accepted while a commit is pending.
REQ-012 SHALL commit shadow to active (functions={6'b0,FUNC}, period, compare1, compare2, prescale) on the first cycle, while armed, that is a wrap tick or has pwm_en=0; upd_pending SHALL clear on that cycle.
REQ-013 SHALL NOT commit on the arming cycle itself, even if a wrap tick coincides with it; the commit SHALL wait for the next qualifying cycle.
REQ-014 SHALL generate the tick from an 8-bit prescale counter: tick=1 when the counter equals the active prescale, and the counter SHALL then return to 0. Prescale 0 SHALL give a tick every cycle.
REQ-015 SHALL increment count_val by 1 on each tick when pwm_en=1. When count_val equals period-1 on a tick (wrap tick), count_val SHALL go to 0 and period_irq SHALL pulse for 1 cycle.
REQ-016 SHALL treat period 0 as 1: count_val stays 0 and every tick is a wrap tick.
REQ-017 SHALL wrap count_val to 0 on the next tick when a commit lowers period to or below the current count_val.
REQ-018 SHALL hold count_val and the prescale counter at 0 and period_irq at 0 while pwm_en=0; counting SHALL restart from 0 on enable.
REQ-019 SHALL apply newly committed values from count_val=0 when the commit occurs on a wrap tick.

Reset
REQ-020 SHALL, on rst_n=0, clear all outputs, shadow and active registers, the prescale counter and CTRL to 0, and set cfg_ready to 1; this SHALL take effect immediately, asynchronously.
REQ-021 SHALL abandon a pending commit on a reset during operation; no shadow values SHALL reach the outputs.

Configuration
REQ-022 SHALL, with PWM_CTRL_ONESHOT_EN defined, honour CTRL.ONESHOT: on a wrap tick with ONESHOT=1, EN SHALL clear, pwm_en SHALL drop the next cycle and period_irq SHALL still pulse.
REQ-023 SHALL, with PWM_CTRL_ONESHOT_EN undefined, ignore ONESHOT; counting SHALL run continuously and no one-shot logic SHALL be present.

Verification
REQ-024 SHALL verify: reset, then write PERIOD=4, UPD=1 with EN=0 -> commit next cycle, period=4, upd_pending=0, cfg_ready=1.
REQ-025 SHALL verify: PERIOD=4, PRESCALE=0, EN=1 -> count_val 0,1,2,3,0; period_irq high on the cycle count_val returns to 0.
REQ-026 SHALL verify: while running, write CMP1=2, then UPD=1 at count_val=1 -> compare1 unchanged until the wrap tick; cfg_ready=0 until then; a write attempted meanwhile is not accepted.
REQ-027 SHALL verify: PRESCALE=2, PERIOD=3 -> count_val advances every 3rd cycle; period 0 -> count_val stays 0 and period_irq pulses each tick.
REQ-028 SHALL verify: rst_n asserted mid-count with a commit armed -> all outputs 0 immediately; no commit after reset is released.
REQ-029 SHALL verify: with PWM_CTRL_ONESHOT_EN defined and ONESHOT=1, EN=1 -> one full period, then pwm_en=0 and count_val=0; without the macro, counting continues.

Source files
------------

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: config front end for a PWM generator; EN is live, all other settings are shadowed and committed together.
// Latency: a write lands one clk after acceptance; shadows reach the outputs on the first wrap tick (or idle cycle) after UPD.
// Backpressure: cfg_ready is low while a commit is armed. Optional one-shot mode: define PWM_CTRL_ONESHOT_EN.
module pwm_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        pwm_en,
  output logic [7:0]  functions,
  output logic [15:0] period,
  output logic [15:0] compare1,
  output logic [15:0] compare2,
  output logic [15:0] count_val,
  output logic        period_irq,
  output logic        upd_pending
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_CMP1   = 3'd2;
  localparam logic [2:0] A_CMP2   = 3'd3;
  localparam logic [2:0] A_PRESC  = 3'd4;

  logic        en_q;
  logic        en_next;
  logic [1:0]  func_sh;
  logic [15:0] period_sh;
  logic [15:0] cmp1_sh;
  logic [15:0] cmp2_sh;
  logic [7:0]  presc_sh;
  logic [7:0]  presc_act;
  logic [7:0]  presc_cnt;
  logic        wr;
  logic        ctrl_wr;
  logic        tick;
  logic        wrap_tick;
  logic        commit;
`ifdef PWM_CTRL_ONESHOT_EN
  logic        oneshot_q;
`endif

  // No writes while a commit is armed, so shadows cannot change under a pending commit.
  assign cfg_ready = !upd_pending;
  assign wr        = cfg_valid && cfg_ready;
  assign ctrl_wr   = wr && (cfg_addr == A_CTRL);
  assign pwm_en    = en_q;

  // Period 0 behaves as 1; a count at or above period-1 (after a period shrink) also wraps.
  assign tick      = en_q && (presc_cnt == presc_act);
  assign wrap_tick = tick && ((period == 16'd0) || (count_val >= period - 16'd1));

  // upd_pending is still 0 on the arming cycle, so a coincident wrap cannot commit early.
  assign commit    = upd_pending && (wrap_tick || !en_q);

  // Next enable: software write wins; one-shot drops EN on the wrap tick.
  always_comb begin
    en_next = en_q;
    if (ctrl_wr) begin
      en_next = cfg_wdata[0];
    end
`ifdef PWM_CTRL_ONESHOT_EN
    else if (wrap_tick && oneshot_q) begin
      en_next = 1'b0;
    end
`endif
  end

  // CTRL bits, shadow registers and commit arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      func_sh     <= 2'd0;
      period_sh   <= 16'd0;
      cmp1_sh     <= 16'd0;
      cmp2_sh     <= 16'd0;
      presc_sh    <= 8'd0;
      upd_pending <= 1'b0;
`ifdef PWM_CTRL_ONESHOT_EN
      oneshot_q   <= 1'b0;
`endif
    end else begin
      en_q <= en_next;
      if (wr) begin
        case (cfg_addr)
          A_CTRL: begin
            func_sh <= cfg_wdata[2:1];
`ifdef PWM_CTRL_ONESHOT_EN
            oneshot_q <= cfg_wdata[4];
`endif
          end
          A_PERIOD: period_sh <= cfg_wdata;
          A_CMP1:   cmp1_sh   <= cfg_wdata;
          A_CMP2:   cmp2_sh   <= cfg_wdata;
          A_PRESC:  presc_sh  <= cfg_wdata[7:0];
          default:  ;
        endcase
      end
      if (ctrl_wr && cfg_wdata[3]) begin
        upd_pending <= 1'b1;
      end else if (commit) begin
        upd_pending <= 1'b0;
      end
    end
  end

  // Shadow-to-active transfer, all fields together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      functions <= 8'd0;
      period    <= 16'd0;
      compare1  <= 16'd0;
      compare2  <= 16'd0;
      presc_act <= 8'd0;
    end else if (commit) begin
      functions <= {6'd0, func_sh};
      period    <= period_sh;
      compare1  <= cmp1_sh;
      compare2  <= cmp2_sh;
      presc_act <= presc_sh;
    end
  end

  // Prescaler and period counter; both sit at 0 whenever the generator is (or is becoming) disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt  <= 8'd0;
      count_val  <= 16'd0;
      period_irq <= 1'b0;
    end else begin
      period_irq <= wrap_tick;
      if (!en_next) begin
        presc_cnt <= 8'd0;
        count_val <= 16'd0;
      end else if (tick) begin
        presc_cnt <= 8'd0;
        count_val <= wrap_tick ? 16'd0 : count_val + 16'd1;
      end else if (en_q) begin
        presc_cnt <= presc_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: directed vectors with hand-computed expectations for pwm_ctrl.
// Inputs are driven and outputs sampled at the falling clock edge.
// Run with or without PWM_CTRL_ONESHOT_EN; the one-shot expectations follow the macro.
module tb_pwm_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        pwm_en;
  logic [7:0]  functions;
  logic [15:0] period;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [15:0] count_val;
  logic        period_irq;
  logic        upd_pending;

  int errors = 0;
  int checks = 0;

  pwm_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .pwm_en      (pwm_en),
    .functions   (functions),
    .period      (period),
    .compare1    (compare1),
    .compare2    (compare2),
    .count_val   (count_val),
    .period_irq  (period_irq),
    .upd_pending (upd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One write presented for one cycle; returns at the falling edge after the accepting edge.
  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = 3'd0;
    cfg_wdata = 16'd0;
    #3;
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_period", period, 0);
    chk("rst_count", count_val, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_pending", upd_pending, 0);
    chk("rst_irq", period_irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Shadow write, then commit while disabled.
    wr(3'd1, 16'd4);
    chk("shadow_only", period, 0);
    wr(3'd0, 16'h0008);
    chk("armed_pending", upd_pending, 1);
    chk("armed_ready", cfg_ready, 0);
    @(negedge clk);
    chk("commit_period", period, 4);
    chk("commit_pending", upd_pending, 0);
    chk("commit_ready", cfg_ready, 1);

    // Free-running count, period 4, prescale 0.
    wr(3'd0, 16'h0001);
    chk("en_pwm_en", pwm_en, 1);
    chk("en_count0", count_val, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("run_count", count_val, i % 4);
      chk("run_irq", period_irq, (i == 4) ? 1 : 0);
    end

    // Commit while running waits for the wrap tick; writes blocked meanwhile.
    wr(3'd2, 16'd2);
    chk("cmp_wr_count", count_val, 1);
    wr(3'd0, 16'h0009);
    chk("upd_count", count_val, 2);
    chk("upd_pending", upd_pending, 1);
    chk("upd_ready", cfg_ready, 0);
    chk("upd_cmp_hold", compare1, 0);
    cfg_valid = 1'b1;
    cfg_addr  = 3'd2;
    cfg_wdata = 16'd7;
    @(negedge clk);
    chk("wait_count", count_val, 3);
    chk("wait_cmp_hold", compare1, 0);
    chk("wait_pending", upd_pending, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("wrap_cmp", compare1, 2);
    chk("wrap_count", count_val, 0);
    chk("wrap_irq", period_irq, 1);
    chk("wrap_pending", upd_pending, 0);
    chk("wrap_ready", cfg_ready, 1);

    // Prescale 2, period 3.
    wr(3'd4, 16'd2);
    wr(3'd1, 16'd3);
    wr(3'd0, 16'h0008);
    chk("dis_count", count_val, 0);
    chk("dis_pwm_en", pwm_en, 0);
    @(negedge clk);
    chk("p3_period", period, 3);
    wr(3'd0, 16'h0001);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("presc_count", count_val, (k / 3) % 3);
      chk("presc_irq", period_irq, (k == 9) ? 1 : 0);
    end

    // Period 0: count stays 0, irq every tick.
    wr(3'd4, 16'd0);
    wr(3'd1, 16'd0);
    wr(3'd0, 16'h0008);
    @(negedge clk);
    chk("p0_period", period, 0);
    wr(3'd0, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("p0_count", count_val, 0);
      chk("p0_irq", period_irq, 1);
    end

    // Reset mid-count with a commit armed.
    wr(3'd1, 16'd8);
    wr(3'd0, 16'h0008);
    @(negedge clk);
    chk("p8_period", period, 8);
    wr(3'd0, 16'h0001);
    repeat (3) @(negedge clk);
    wr(3'd1, 16'd2);
    wr(3'd0, 16'h0009);
    chk("mid_count", count_val, 5);
    chk("mid_pending", upd_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm_en", pwm_en, 0);
    chk("arst_period", period, 0);
    chk("arst_count", count_val, 0);
    chk("arst_cmp1", compare1, 0);
    chk("arst_pending", upd_pending, 0);
    chk("arst_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_period", period, 0);
    chk("post_pending", upd_pending, 0);
    chk("post_pwm_en", pwm_en, 0);
    chk("post_count", count_val, 0);

    // One-shot: EN=1, ONESHOT=1, period 3.
    wr(3'd1, 16'd3);
    wr(3'd0, 16'h0008);
    @(negedge clk);
    chk("os_period", period, 3);
    wr(3'd0, 16'h0011);
    repeat (2) @(negedge clk);
    chk("os_count2", count_val, 2);
    @(negedge clk);
    chk("os_wrap_count", count_val, 0);
    chk("os_wrap_irq", period_irq, 1);
`ifdef PWM_CTRL_ONESHOT_EN
    chk("os_wrap_en", pwm_en, 0);
    @(negedge clk);
    chk("os_after_count", count_val, 0);
    chk("os_after_en", pwm_en, 0);
`else
    chk("os_wrap_en", pwm_en, 1);
    @(negedge clk);
    chk("os_after_count", count_val, 1);
    chk("os_after_en", pwm_en, 1);
`endif
    chk("os_after_irq", period_irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
